// File: rtl/shift_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : shift_unit_pkg                                          |
// | Purpose  : Shared operation and state encodings for shift_unit.    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package shift_unit_pkg;

  // Operation encodings as presented on the op port
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : shift_unit_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : shift_step                                              |
// | Purpose  : Combinational single-position shift/rotate step.        |
// | Config   : SHIFT_UNIT_ROTATE_EN enables rotate-right on OP_ROR;    |
// |            without it OP_ROR zero-fills exactly like OP_SRL.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value
);

  // One-bit step selected by the latched operation
  always_comb begin
    next_value = {1'b0, value[WIDTH-1:1]};
    case (op)
      OP_SLL: next_value = {value[WIDTH-2:0], 1'b0};
      OP_SRL: next_value = {1'b0, value[WIDTH-1:1]};
      OP_SRA: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR: next_value = {value[0], value[WIDTH-1:1]};
`else
      OP_ROR: next_value = {1'b0, value[WIDTH-1:1]};
`endif
      default: next_value = {1'b0, value[WIDTH-1:1]};
    endcase
  end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : shift_unit                                              |
// | Purpose  : Multi-cycle shifter, one bit position per clock, with   |
// |            start/busy/done handshake and synchronous flush.        |
// | Config   : SHIFT_UNIT_ROTATE_EN (see shift_step) adds rotate-right |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               flush,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_result;
  logic [SHAMT_W-1:0]   r_count;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     w_step_value;
  logic                 w_load;
  logic                 w_step;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op         (r_op),
    .value      (r_result),
    .next_value (w_step_value)
  );

  // State register; reset drops any operation in flight without a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus load/step strobes; flush outranks start everywhere
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (flush) begin
          w_state_next = ST_IDLE;
        end else if (start) begin
          w_state_next = ST_SHIFT;
          w_load       = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          w_state_next = ST_IDLE;
        end else if (r_count == '0) begin
          w_state_next = ST_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand, remaining count and operation; result holds when neither strobe fires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_count  <= '0;
      r_op     <= OP_SLL;
    end else if (w_load) begin
      r_result <= data_in;
      r_count  <= shamt;
      r_op     <= op;
    end else if (w_step) begin
      r_result <= w_step_value;
      r_count  <= r_count - SHAMT_W'(1);
    end
  end

  // Outputs decode straight from flops, so no input-to-output path exists
  assign result = r_result;
  assign busy   = (r_state == ST_SHIFT);
  assign done   = (r_state == ST_DONE);

endmodule : shift_unit
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_shift_unit                                           |
// | Purpose  : Directed self-checking bench for shift_unit.            |
// | Config   : honours SHIFT_UNIT_ROTATE_EN for the op=11 vector.      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_shift_unit;
  import shift_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;

  shift_unit #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Done pulses seen at each rising edge (lags done by one edge)
  always @(posedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One operation: latency shamt+1, busy for shamt+1 cycles, done exclusive of busy, one-cycle done
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_res, input bit poke);
    int k;
    int bcyc;
    @(negedge clk);
    op = o; data_in = d; shamt = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    bcyc = 0;
    while (!done && k < 200) begin
      if (busy) bcyc++;
      if (poke && k == 1) begin
        start = 1'b1; data_in = 32'hDEAD_BEEF; shamt = 5'd7; op = OP_SLL;
      end
      if (poke && k == 2) start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(k), 32'(s) + 32'd1);
    chk({tag, " busy_cycles"}, 32'(bcyc), 32'(s) + 32'd1);
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " result"}, result, exp_res);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n0;
    int k;
    logic [31:0] ror_exp;

    // Reset values
    #12;
    chk("rst result", result, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("sll31", OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    run_op("sra4",  OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
    run_op("srl4",  OP_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0);
    run_op("sh0",   OP_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
    run_op("sra_pos", OP_SRA, 32'h7000_0000, 5'd3, 32'h0E00_0000, 1'b0);
    run_op("sll4",  OP_SLL, 32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50, 1'b0);

    // Start pulses during SHIFT are ignored: exactly one done for one accepted start
    n0 = n_done;
    run_op("ignore", OP_SRL, 32'hF0F0_0000, 5'd6, 32'h03C3_C000, 1'b1);
    chk("ignore done_count", 32'(n_done - n0), 32'd1);
    repeat (3) @(negedge clk);
    chk("idle hold result", result, 32'h03C3_C000);

`ifdef SHIFT_UNIT_ROTATE_EN
    ror_exp = 32'h8000_0000;
`else
    ror_exp = 32'h0000_0000;
`endif
    run_op("op11", OP_ROR, 32'h0000_0001, 5'd1, ror_exp, 1'b0);

    // Back-to-back: start held through DONE; 4 idle-of-done cycles between pulses for shamt2=3
    @(negedge clk);
    op = OP_SLL; data_in = 32'h0000_0003; shamt = 5'd2; start = 1'b1;
    @(negedge clk);
    op = OP_SRL; data_in = 32'h0000_00F0; shamt = 5'd3;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b2b first latency", 32'(k), 32'd3);
    chk("b2b first result", result, 32'h0000_000C);
    @(negedge clk);
    start = 1'b0;
    chk("b2b second accepted", {31'd0, busy}, 32'd1);
    k = 0;
    while (!done && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("b2b gap", 32'(k), 32'd4);
    chk("b2b second result", result, 32'h0000_001E);
    @(negedge clk);

    // Flush on the third edge of SLL by 10: two steps taken, no done
    n0 = n_done;
    op = OP_SLL; data_in = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    chk("flush result", result, 32'h0000_0004);
    repeat (15) @(negedge clk);
    chk("flush no done", 32'(n_done - n0), 32'd0);
    chk("flush hold", result, 32'h0000_0004);

    // Flush beats start in IDLE: no load
    start = 1'b1; flush = 1'b1; data_in = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_prio busy", {31'd0, busy}, 32'd0);
    chk("flush_prio result", result, 32'h0000_0004);

    // Asynchronous reset mid-shift
    n0 = n_done;
    op = OP_SLL; data_in = 32'h0000_FFFF; shamt = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst result", result, 32'h0);
    chk("async_rst busy", {31'd0, busy}, 32'd0);
    chk("async_rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    chk("async_rst no done", 32'(n_done - n0), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_shift_unit
`default_nettype wire
